// File: rtl/tetris_pkg.sv
// tetris_pkg: shared constants for the playfield engine.
//   - Default board geometry (rows, columns, game-over band, counter width).
//   - Row/column index widths derived from the default geometry.
//   - Wipe FSM state encoding (2-bit IDLE=0, WIPE=1, DONE=2).
package tetris_pkg;

    localparam int DEFAULT_ROWS     = 20;
    localparam int DEFAULT_COLS     = 10;
    localparam int DEFAULT_TOP_ROWS = 2;
    localparam int DEFAULT_CNT_W    = 8;

    localparam int ROW_W = $clog2(DEFAULT_ROWS);
    localparam int COL_W = $clog2(DEFAULT_COLS);

    typedef logic [1:0] wipe_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WIPE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_row_finder.sv
// full_row_finder: combinational priority encoder over the board rows.
// Ports:
//   board    in   ROWS x COLS occupancy, row 0 on top
//   any_full out  at least one row has every column set
//   full_idx out  largest index of a full row (lowest on screen); 0 if none
module full_row_finder
    import tetris_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS
) (
    input  logic [ROWS-1:0][COLS-1:0] board,
    output logic                      any_full,
    output logic [$clog2(ROWS)-1:0]   full_idx
);

    localparam int R_W = $clog2(ROWS);

    // Ascending scan: the last full row seen is the bottom-most one.
    always_comb begin
        any_full = 1'b0;
        full_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (&board[i]) begin
                any_full = 1'b1;
                full_idx = R_W'(i);
            end
        end
    end

endmodule

// File: rtl/board_engine.sv
// board_engine: settled-block playfield behind the game controller.
// Locks landed pieces into the board, collapses one full row per remove
// request, wipes the board row by row on request and exposes a row read
// port for the display.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   transform_en          lock piece_mask at (piece_row, piece_col)
//   remove_en             collapse the bottom-most full row
//   clear_en              wipe request, held until done
//   piece_mask            4x4 bitmap, bit 4*r+c -> (piece_row+r, piece_col+c)
//   piece_row, piece_col  placement of mask cell (0,0)
//   rd_row / rd_data      combinational row read, 0 for rows past the board
//   remove                some row is full
//   game_over             some cell set in the top TOP_ROWS rows
//   done                  wipe finished (registered)
//   lines_cnt             rows removed since last wipe, saturating
module board_engine
    import tetris_pkg::*;
#(
    parameter int ROWS     = DEFAULT_ROWS,
    parameter int COLS     = DEFAULT_COLS,
    parameter int TOP_ROWS = DEFAULT_TOP_ROWS,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    transform_en,
    input  logic                    remove_en,
    input  logic                    clear_en,
    input  logic [15:0]             piece_mask,
    input  logic [$clog2(ROWS)-1:0] piece_row,
    input  logic [$clog2(COLS)-1:0] piece_col,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data,
    output logic                    remove,
    output logic                    game_over,
    output logic                    done,
    output logic [CNT_W-1:0]        lines_cnt
);

    localparam int R_W = $clog2(ROWS);

    logic [ROWS-1:0][COLS-1:0] board;
    logic [ROWS-1:0][COLS-1:0] placed;
    logic [ROWS-1:0][COLS-1:0] collapsed;
    logic                      any_full;
    logic [R_W-1:0]            full_idx;
    wipe_state_t               state;
    logic [R_W-1:0]            wptr;

    full_row_finder #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_finder (
        .board    (board),
        .any_full (any_full),
        .full_idx (full_idx)
    );

    // Piece projected onto the board. Only in-board cells are ever
    // enumerated, so mask cells past the right or bottom edge drop out.
    always_comb begin
        placed = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        if (piece_mask[4*r+c] &&
                            (int'(piece_row) + r == i) &&
                            (int'(piece_col) + c == j)) begin
                            placed[i][j] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Board with the target row removed: everything above it drops one row.
    always_comb begin
        collapsed    = board;
        collapsed[0] = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(full_idx)) begin
                collapsed[i] = board[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            board     <= '0;
            lines_cnt <= '0;
            done      <= 1'b0;
            state     <= ST_IDLE;
            wptr      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_en) begin
                        state <= ST_WIPE;
                        wptr  <= '0;
                    end else if (transform_en) begin
                        board <= board | placed;
                    end else if (remove_en && any_full) begin
                        board <= collapsed;
                        if (lines_cnt != '1) begin
                            lines_cnt <= lines_cnt + 1'b1;
                        end
                    end
                end
                ST_WIPE: begin
                    for (int i = 0; i < ROWS; i++) begin
                        if (wptr == R_W'(i)) begin
                            board[i] <= '0;
                        end
                    end
                    wptr <= wptr + 1'b1;
                    if (wptr == R_W'(ROWS - 1)) begin
                        lines_cnt <= '0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A request dropped mid-wipe lands here too and is
                    // released on the following cycle.
                    if (!clear_en) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rd_row == R_W'(i)) begin
                rd_data = board[i];
            end
        end
    end

    assign remove    = any_full;
    assign game_over = |board[TOP_ROWS-1:0];

endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: table-driven lock/collapse vectors, hand-written wipe
// and reset sequences, then randomized traffic against a row-list model.
module tb_board_engine;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int CNT_W = 8;
    localparam int RW    = 5;
    localparam int CW    = 4;

    logic            clk;
    logic            reset_n;
    logic            transform_en;
    logic            remove_en;
    logic            clear_en;
    logic [15:0]     piece_mask;
    logic [RW-1:0]   piece_row;
    logic [CW-1:0]   piece_col;
    logic [RW-1:0]   rd_row;
    logic [COLS-1:0] rd_data;
    logic            remove;
    logic            game_over;
    logic            done;
    logic [CNT_W-1:0] lines_cnt;

    board_engine #(
        .ROWS(ROWS), .COLS(COLS), .TOP_ROWS(2), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .transform_en (transform_en),
        .remove_en    (remove_en),
        .clear_en     (clear_en),
        .piece_mask   (piece_mask),
        .piece_row    (piece_row),
        .piece_col    (piece_col),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .remove       (remove),
        .game_over    (game_over),
        .done         (done),
        .lines_cnt    (lines_cnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int r, output logic [COLS-1:0] d);
        rd_row = r[RW-1:0];
        #1;
        d = rd_data;
    endtask

    task automatic board_or(output logic [COLS-1:0] acc);
        logic [COLS-1:0] d;
        acc = '0;
        for (int i = 0; i < ROWS; i++) begin
            rd(i, d);
            acc |= d;
        end
    endtask

    task automatic idle_in();
        transform_en = 1'b0;
        remove_en    = 1'b0;
        clear_en     = 1'b0;
    endtask

    task automatic do_reset();
        logic [COLS-1:0] acc;
        @(negedge clk);
        idle_in();
        reset_n = 1'b0;
        #2;
        chk("rst_done", done, 0);
        chk("rst_cnt", lines_cnt, 0);
        chk("rst_remove", remove, 0);
        chk("rst_gover", game_over, 0);
        board_or(acc);
        chk("rst_board", acc, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    // ---------------- reference model: board as a list of rows -----------
    logic [COLS-1:0] m[ROWS];
    int mcnt;

    function automatic void m_clear();
        for (int i = 0; i < ROWS; i++) m[i] = '0;
        mcnt = 0;
    endfunction

    function automatic void m_lock(input logic [15:0] mask, input int pr, input int pc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[4*r+c] && pr + r < ROWS && pc + c < COLS)
                    m[pr+r][pc+c] = 1'b1;
    endfunction

    function automatic void m_collapse();
        logic [COLS-1:0] q[$];
        int t = -1;
        for (int i = 0; i < ROWS; i++) if (m[i] == '1) t = i;
        if (t < 0) return;
        for (int i = 0; i < ROWS; i++) q.push_back(m[i]);
        q.delete(t);
        q.push_front('0);
        for (int i = 0; i < ROWS; i++) m[i] = q[i];
        if (mcnt < 255) mcnt++;
    endfunction

    function automatic logic m_remove();
        for (int i = 0; i < ROWS; i++) if (m[i] == '1) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        te, re;
        logic [15:0] mask;
        int          prow, pcol, crow;
        logic [9:0]  erow;
        logic        erem, ego;
        int          ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic te, input logic re, input logic [15:0] mask,
                        input int prow, input int pcol, input int crow,
                        input logic [9:0] erow, input logic erem, input logic ego,
                        input int ecnt);
        vec_t v;
        v.te = te; v.re = re; v.mask = mask; v.prow = prow; v.pcol = pcol;
        v.crow = crow; v.erow = erow; v.erem = erem; v.ego = ego; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [COLS-1:0] d;
        logic [COLS-1:0] acc;
        logic [15:0]     mask;
        int prow, pcol, sel, r;
        bit seen;

        reset_n = 1'b1; idle_in();
        piece_mask = '0; piece_row = '0; piece_col = '0; rd_row = '0;

        //    te re mask    prow pcol crow erow    rem go cnt
        addv(1, 0, 16'h000F, 19, 0, 19, 10'h00F, 0, 0, 0);
        addv(1, 0, 16'h0003, 19, 4, 19, 10'h03F, 0, 0, 0);
        addv(1, 0, 16'h000F, 19, 6, 19, 10'h3FF, 1, 0, 0);
        addv(0, 1, 16'h0000,  0, 0, 19, 10'h000, 0, 0, 1);
        addv(0, 0, 16'h0000,  0, 0,  0, 10'h000, 0, 0, 1);
        addv(1, 0, 16'h0005, 17, 0, 17, 10'h005, 0, 0, 1);
        addv(1, 0, 16'h0005, 17, 4, 17, 10'h055, 0, 0, 1);
        addv(1, 0, 16'h0001, 17, 8, 17, 10'h155, 0, 0, 1);
        addv(1, 0, 16'h00FF, 18, 0, 18, 10'h00F, 0, 0, 1);
        addv(1, 0, 16'h00FF, 18, 4, 19, 10'h0FF, 0, 0, 1);
        addv(1, 0, 16'h0033, 18, 8, 18, 10'h3FF, 1, 0, 1);
        addv(0, 1, 16'h0000,  0, 0, 18, 10'h155, 1, 0, 2);
        addv(0, 1, 16'h0000,  0, 0, 19, 10'h155, 0, 0, 3);
        addv(0, 1, 16'h0000,  0, 0, 19, 10'h155, 0, 0, 3);
        addv(0, 0, 16'h0000,  0, 0, 18, 10'h000, 0, 0, 3);
        addv(1, 0, 16'h0001,  1, 4,  1, 10'h010, 0, 1, 3);
        addv(1, 0, 16'h0003,  5, 9,  5, 10'h200, 0, 1, 3);
        addv(1, 0, 16'h1001, 18, 0, 18, 10'h001, 0, 1, 3);
        addv(0, 0, 16'h0000,  0, 0, 25, 10'h000, 0, 1, 3);
        addv(1, 0, 16'h000A, 19, 0, 19, 10'h15F, 0, 1, 3);
        addv(1, 0, 16'h000A, 19, 4, 19, 10'h1FF, 0, 1, 3);
        addv(1, 0, 16'h0002, 19, 8, 19, 10'h3FF, 1, 1, 3);
        addv(1, 1, 16'h0001,  3, 0, 19, 10'h3FF, 1, 1, 3);
        addv(0, 0, 16'h0000,  0, 0,  3, 10'h001, 1, 1, 3);
        addv(0, 1, 16'h0000,  0, 0, 19, 10'h001, 0, 0, 4);
        addv(0, 0, 16'h0000,  0, 0,  2, 10'h010, 0, 0, 4);
        addv(0, 0, 16'h0000,  0, 0,  4, 10'h001, 0, 0, 4);
        addv(0, 0, 16'h0000,  0, 0,  6, 10'h200, 0, 0, 4);

        do_reset();

        foreach (tbl[k]) begin
            transform_en = tbl[k].te;
            remove_en    = tbl[k].re;
            piece_mask   = tbl[k].mask;
            piece_row    = tbl[k].prow[RW-1:0];
            piece_col    = tbl[k].pcol[CW-1:0];
            step();
            idle_in();
            rd(tbl[k].crow, d);
            chk($sformatf("v%0d_row%0d", k, tbl[k].crow), d, tbl[k].erow);
            chk($sformatf("v%0d_remove", k), remove, tbl[k].erem);
            chk($sformatf("v%0d_gover", k), game_over, tbl[k].ego);
            chk($sformatf("v%0d_cnt", k), lines_cnt, tbl[k].ecnt);
        end

        // ---- wipe with clear held, lock requests held throughout ----
        clear_en = 1'b1;
        transform_en = 1'b1; piece_mask = 16'hFFFF; piece_row = 5'd16; piece_col = 4'd0;
        for (int k = 1; k <= 21; k++) begin
            step();
            chk($sformatf("wipe_done_c%0d", k), done, (k == 21) ? 1 : 0);
        end
        chk("wipe_cnt", lines_cnt, 0);
        board_or(acc);
        chk("wipe_board", acc, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wipe_done_hold", done, 1);
        end
        board_or(acc);
        chk("wipe_board_hold", acc, 0);
        idle_in();
        step();
        chk("wipe_done_drop", done, 0);

        // back in IDLE: locks work again
        transform_en = 1'b1; piece_mask = 16'h00FF; piece_row = 5'd10; piece_col = 4'd0;
        step();
        idle_in();
        rd(10, d);
        chk("post_wipe_lock", d, 10'h00F);

        // ---- reset in the middle of a wipe ----
        clear_en = 1'b1;
        for (int k = 0; k < 7; k++) step();
        reset_n = 1'b0;
        clear_en = 1'b0;
        #1;
        chk("midwipe_rst_done", done, 0);
        chk("midwipe_rst_cnt", lines_cnt, 0);
        board_or(acc);
        chk("midwipe_rst_board", acc, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        transform_en = 1'b1; piece_mask = 16'h000F; piece_row = 5'd0; piece_col = 4'd0;
        step();
        piece_row = 5'd19;
        step();
        idle_in();
        clear_en = 1'b1;
        step();
        step();
        rd(0, d);
        chk("restart_row0", d, 0);
        rd(19, d);
        chk("restart_row19", d, 10'h00F);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            seen = done;
        end
        chk("restart_done_seen", seen, 1);
        board_or(acc);
        chk("restart_board", acc, 0);
        idle_in();
        step();

        // ---- randomized traffic vs. row-list model ----
        do_reset();
        m_clear();
        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 79) begin
                do_reset();
                m_clear();
            end
            sel  = $urandom_range(0, 9);
            mask = ($urandom_range(0, 2) == 0) ? 16'hFFFF :
                   ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'($urandom);
            prow = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(10, 19);
            pcol = $urandom_range(0, 15);
            transform_en = (sel < 5) || (sel == 8);
            remove_en    = (sel >= 5 && sel < 9);
            piece_mask   = mask;
            piece_row    = prow[RW-1:0];
            piece_col    = pcol[CW-1:0];
            if (transform_en) m_lock(mask, prow, pcol);
            else if (remove_en) m_collapse();
            step();
            idle_in();
            r = $urandom_range(0, ROWS - 1);
            rd(r, d);
            chk($sformatf("rnd%0d_row%0d", n, r), d, m[r]);
            chk($sformatf("rnd%0d_remove", n), remove, m_remove());
            chk($sformatf("rnd%0d_gover", n), game_over, (m[0] != 0) || (m[1] != 0));
            chk($sformatf("rnd%0d_cnt", n), lines_cnt, mcnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
